// File: rtl/tree_walk_ctrl_pkg.sv
// Shared types and constants for the message-tree walker.
// Dependency table and node-data ROM live here.
package tree_walk_ctrl_pkg;

  localparam int NUM_MSG_HIERARCHY = 2;
  localparam int NUM_MSGS = 2;
  localparam int IDENTIFIER_SIZE = 5;
  localparam int LEN_W = 16;
  localparam int DEPTH_W = $clog2(NUM_MSG_HIERARCHY + 1);
  localparam int IDX_W = $clog2(NUM_MSGS);

  typedef logic [IDENTIFIER_SIZE-1:0] id_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef logic [DEPTH_W-1:0] depth_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Position 0 is the outermost message id.
  typedef id_t [NUM_MSG_HIERARCHY-1:0] dependency_t;
  typedef len_t [NUM_MSG_HIERARCHY-1:0] len_arr_t;
  typedef dependency_t [NUM_MSGS-1:0] dependency_arr_t;

  typedef struct packed {
    logic [7:0] num_fields;
    logic [7:0] base;
  } msg_t;
  typedef msg_t [NUM_MSGS-1:0] msg_arr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    EMIT,
    ERR
  } state_t;

  // [1] PhoneNumber = {1,4}, [0] Person = {1,0}
  localparam dependency_arr_t DEPENDENCY = {
    5'd4, 5'd1,
    5'd0, 5'd1
  };

  localparam msg_arr_t NODE_DATA = {
    8'd4, 8'd5,
    8'd5, 8'd0
  };

  function automatic logic path_eq(
    input dependency_t a,
    input dependency_t b
  );
    return a == b;
  endfunction

endpackage

// File: rtl/tree_walk_ctrl_if.sv
// Tag-in and node-out handshakes of the tree walker.
// slave = controller side, master = decoder/consumer side.
interface tree_walk_ctrl_if;
  import tree_walk_ctrl_pkg::*;

  logic tag_valid;
  logic tag_ready;
  id_t  tag_id;
  logic tag_nested;
  len_t tag_len;
  logic node_valid;
  logic node_ready;
  logic node_hit;
  idx_t node_idx;

  modport slave (
    input  tag_valid, tag_id, tag_nested, tag_len,
    input  node_ready,
    output tag_ready,
    output node_valid, node_hit, node_idx
  );

  modport master (
    output tag_valid, tag_id, tag_nested, tag_len,
    output node_ready,
    input  tag_ready,
    input  node_valid, node_hit, node_idx
  );

endinterface

// File: rtl/tree_level_stack.sv
// Stack of open messages (id, remaining bytes).
// Byte decrement, multi-level pop, then optional push.
module tree_level_stack
  import tree_walk_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        dec,
  input  logic        push,
  input  id_t         push_id,
  input  len_t        push_len,
  output depth_t      depth,
  output dependency_t ids,
  output len_arr_t    rems
);

  depth_t      nd;
  depth_t      depth_n;
  dependency_t ids_n;
  len_arr_t    rems_n;

  // Pops resolve first; a push lands above the surviving levels.
  always_comb begin
    nd = depth;
    for (int i = NUM_MSG_HIERARCHY-1; i >= 0; i--) begin
      if (dec && depth_t'(i) < depth &&
          rems[i] == len_t'(1))
        nd = depth_t'(i);
    end
    ids_n = ids;
    rems_n = rems;
    depth_n = nd;
    for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
      if (depth_t'(i) < nd) begin
        if (dec)
          rems_n[i] = rems[i] - len_t'(1);
      end else begin
        ids_n[i] = '0;
        rems_n[i] = '0;
      end
    end
    if (push &&
        nd < depth_t'(NUM_MSG_HIERARCHY)) begin
      for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
        if (depth_t'(i) == nd) begin
          ids_n[i] = push_id;
          rems_n[i] = push_len;
        end
      end
      depth_n = nd + depth_t'(1);
    end
    if (clear) begin
      ids_n = '0;
      rems_n = '0;
      depth_n = '0;
    end
  end

  // Stack storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      ids <= '0;
      rems <= '0;
    end else begin
      depth <= depth_n;
      ids <= ids_n;
      rems <= rems_n;
    end
  end

endmodule

// File: rtl/tree_walk_ctrl.sv
// Tag sequencer: path match against the dependency
// table, node emit, nested-level bookkeeping.
module tree_walk_ctrl
  import tree_walk_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  tree_walk_ctrl_if.slave bus,
  input  logic     byte_valid,
  input  logic     err_clr,
  output depth_t   depth,
  output logic     err
);

  state_t      state, state_n;
  id_t         cap_id;
  logic        cap_nested;
  len_t        cap_len;
  logic        hit_q;
  idx_t        idx_q;
  logic        push;
  logic        err_c;
  logic        hit_c;
  idx_t        idx_c;
  len_t        parent;
  dependency_t path;
  dependency_t ids;
  len_arr_t    rems;

  tree_level_stack u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (err_clr),
    .dec      (byte_valid && state != ERR),
    .push     (push),
    .push_id  (cap_id),
    .push_len (cap_len),
    .depth    (depth),
    .ids      (ids),
    .rems     (rems)
  );

  // Tag legality against the innermost open level.
  always_comb begin
    parent = '0;
    for (int i = 0; i < NUM_MSG_HIERARCHY; i++)
      if (depth == depth_t'(i + 1))
        parent = rems[i];
    err_c = (bus.tag_id == '0) ||
      (bus.tag_nested &&
       depth == depth_t'(NUM_MSG_HIERARCHY)) ||
      (bus.tag_nested && depth != '0 &&
       bus.tag_len > parent);
  end

  // Candidate path and lowest-index table match.
  always_comb begin
    path = '0;
    for (int i = 0; i < NUM_MSG_HIERARCHY; i++) begin
      if (depth_t'(i) < depth)
        path[i] = ids[i];
      else if (depth_t'(i) == depth)
        path[i] = cap_id;
    end
    hit_c = 1'b0;
    idx_c = '0;
    for (int j = NUM_MSGS-1; j >= 0; j--) begin
      if (path_eq(DEPENDENCY[j], path)) begin
        hit_c = 1'b1;
        idx_c = idx_t'(j);
      end
    end
  end

  // Next state and push strobe.
  always_comb begin
    state_n = state;
    push = 1'b0;
    if (err_clr) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (bus.tag_valid)
            state_n = err_c ? ERR : LOOKUP;
        LOOKUP:
          state_n = EMIT;
        EMIT:
          if (bus.node_ready) begin
            state_n = IDLE;
            push = cap_nested && cap_len != '0;
          end
        ERR:
          state_n = ERR;
        default:
          state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Captured tag and registered match result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_id <= '0;
      cap_nested <= 1'b0;
      cap_len <= '0;
      hit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      if (state == IDLE && bus.tag_valid &&
          !err_clr) begin
        cap_id <= bus.tag_id;
        cap_nested <= bus.tag_nested;
        cap_len <= bus.tag_len;
      end
      if (state == LOOKUP) begin
        hit_q <= hit_c;
        idx_q <= idx_c;
      end
    end
  end

  assign bus.tag_ready = (state == IDLE);
  assign bus.node_valid = (state == EMIT);
  assign bus.node_hit = hit_q;
  assign bus.node_idx = idx_q;
  assign err = (state == ERR);

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Scoreboard bench for tree_walk_ctrl.
// Expected nodes queued at tag drive, popped on node_valid.
module tb_tree_walk_ctrl;
  import tree_walk_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   byte_valid = 1'b0;
  logic   err_clr = 1'b0;
  depth_t depth;
  logic   err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic hit;
    idx_t idx;
  } exp_t;
  exp_t sb[$];

  tree_walk_ctrl_if bus();

  tree_walk_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .byte_valid (byte_valid),
    .err_clr    (err_clr),
    .depth      (depth),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic send_tag(input id_t id,
                          input logic nested,
                          input len_t len);
    bus.tag_valid = 1'b1;
    bus.tag_id = id;
    bus.tag_nested = nested;
    bus.tag_len = len;
    @(negedge clk);
    bus.tag_valid = 1'b0;
  endtask

  task automatic bytes(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_tag(input string name,
                        input id_t id,
                        input logic nested,
                        input len_t len,
                        input logic hit,
                        input idx_t idx);
    exp_t e;
    exp_t g;
    int lat;
    e.hit = hit;
    e.idx = idx;
    sb.push_back(e);
    checks++;
    if (bus.tag_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s tag_ready got %b want 1",
               name, bus.tag_ready);
    end
    send_tag(id, nested, len);
    lat = 1;
    while (bus.node_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL %s latency got %0d want 2",
               name, lat);
    end
    if (bus.node_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected node got %b/%0d want none",
                 name, bus.node_hit, bus.node_idx);
      end else begin
        g = sb.pop_front();
        if ({bus.node_hit, bus.node_idx} !== g) begin
          errors++;
          $display("FAIL %s node got hit=%b idx=%0d want hit=%b idx=%0d",
                   name, bus.node_hit, bus.node_idx,
                   g.hit, g.idx);
        end
      end
    end
    bus.node_ready = 1'b1;
    @(negedge clk);
    bus.node_ready = 1'b0;
    checks++;
    if (bus.node_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s node_valid after accept got %b want 0",
               name, bus.node_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.node_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_nv got %b want 0", bus.node_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.tag_ready, bus.node_valid, depth, err} !==
        {1'b1, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b nv=%b d=%0d e=%b want 1 0 0 0",
               bus.tag_ready, bus.node_valid, depth, err);
    end
  endtask

  task automatic test_nested_walk();
    do_tag("walk_t1", 5'd1, 1'b1, 16'd6, 1'b1, 1'b0);
    checks++;
    if (depth !== 2'd1) begin
      errors++;
      $display("FAIL walk_d1 depth got %0d want 1", depth);
    end
    bytes(2);
    checks++;
    if (dut.u_stack.rems[0] !== 16'd4) begin
      errors++;
      $display("FAIL walk_rem4 got %0d want 4",
               dut.u_stack.rems[0]);
    end
    do_tag("walk_t4", 5'd4, 1'b1, 16'd3, 1'b1, 1'b1);
    checks++;
    if (depth !== 2'd2) begin
      errors++;
      $display("FAIL walk_d2 depth got %0d want 2", depth);
    end
    bytes(3);
    checks++;
    if (depth !== 2'd1 || dut.u_stack.rems[0] !== 16'd1) begin
      errors++;
      $display("FAIL walk_pop1 got d=%0d rem=%0d want 1 1",
               depth, dut.u_stack.rems[0]);
    end
    bytes(1);
    checks++;
    if (depth !== 2'd0) begin
      errors++;
      $display("FAIL walk_pop0 depth got %0d want 0", depth);
    end
  endtask

  task automatic test_double_pop();
    do_tag("dp_t1", 5'd1, 1'b1, 16'd5, 1'b1, 1'b0);
    bytes(2);
    do_tag("dp_t4", 5'd4, 1'b1, 16'd3, 1'b1, 1'b1);
    bytes(2);
    checks++;
    if (depth !== 2'd2) begin
      errors++;
      $display("FAIL dp_hold depth got %0d want 2", depth);
    end
    bytes(1);
    checks++;
    if (depth !== 2'd0) begin
      errors++;
      $display("FAIL dp_both depth got %0d want 0", depth);
    end
  endtask

  task automatic test_no_match();
    do_tag("nm_t7", 5'd7, 1'b0, 16'd0, 1'b0, 1'b0);
    do_tag("nm_t4", 5'd4, 1'b0, 16'd0, 1'b0, 1'b0);
    do_tag("zl_t1", 5'd1, 1'b1, 16'd0, 1'b1, 1'b0);
    bytes(2);
    checks++;
    if (depth !== 2'd0) begin
      errors++;
      $display("FAIL zero_len depth got %0d want 0", depth);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t g;
    e.hit = 1'b1;
    e.idx = 1'b0;
    sb.push_back(e);
    send_tag(5'd1, 1'b0, 16'd0);
    @(negedge clk);
    checks++;
    if (bus.node_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_nv got %b want 1", bus.node_valid);
    end
    g = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.node_valid, bus.node_hit, bus.node_idx,
           bus.tag_ready} !== {1'b1, g, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d got nv=%b h=%b i=%0d rdy=%b want 1 %b %0d 0",
                 i, bus.node_valid, bus.node_hit,
                 bus.node_idx, bus.tag_ready, g.hit, g.idx);
      end
      @(negedge clk);
    end
    bus.node_ready = 1'b1;
    @(negedge clk);
    bus.node_ready = 1'b0;
    checks++;
    if (bus.node_valid !== 1'b0 || bus.tag_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_take got nv=%b rdy=%b want 0 1",
               bus.node_valid, bus.tag_ready);
    end
  endtask

  task automatic test_errors();
    do_tag("e1_t1", 5'd1, 1'b1, 16'd6, 1'b1, 1'b0);
    do_tag("e1_t4", 5'd4, 1'b1, 16'd3, 1'b1, 1'b1);
    send_tag(5'd5, 1'b1, 16'd1);
    checks++;
    if ({err, bus.tag_ready, bus.node_valid} !== 3'b100) begin
      errors++;
      $display("FAIL err_depth got e=%b rdy=%b nv=%b want 1 0 0",
               err, bus.tag_ready, bus.node_valid);
    end
    bytes(3);
    checks++;
    if (depth !== 2'd2 || dut.u_stack.rems[1] !== 16'd3) begin
      errors++;
      $display("FAIL err_frozen got d=%0d rem=%0d want 2 3",
               depth, dut.u_stack.rems[1]);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if ({err, bus.tag_ready, depth} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL err_clr got e=%b rdy=%b d=%0d want 0 1 0",
               err, bus.tag_ready, depth);
    end
    do_tag("e2_t1", 5'd1, 1'b1, 16'd6, 1'b1, 1'b0);
    bytes(2);
    send_tag(5'd4, 1'b1, 16'd9);
    checks++;
    if (err !== 1'b1 || bus.node_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_len got e=%b nv=%b want 1 0",
               err, bus.node_valid);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    send_tag(5'd0, 1'b0, 16'd0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_id0 got %b want 1", err);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || depth !== 2'd0) begin
      errors++;
      $display("FAIL err_clr2 got e=%b d=%0d want 0 0", err, depth);
    end
  endtask

  task automatic test_clr_in_emit();
    do_tag("ce_t1", 5'd1, 1'b1, 16'd4, 1'b1, 1'b0);
    send_tag(5'd4, 1'b1, 16'd2);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if ({bus.node_valid, bus.tag_ready, depth} !==
        {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL clr_emit got nv=%b rdy=%b d=%0d want 0 1 0",
               bus.node_valid, bus.tag_ready, depth);
    end
  endtask

  task automatic test_reset_in_emit();
    do_tag("re_t1", 5'd1, 1'b1, 16'd4, 1'b1, 1'b0);
    send_tag(5'd4, 1'b1, 16'd2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.node_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_emit_nv got %b want 0", bus.node_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (depth !== 2'd0 || bus.tag_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_emit_post got d=%0d rdy=%b want 0 1",
               depth, bus.tag_ready);
    end
  endtask

  initial begin
    bus.tag_valid = 1'b0;
    bus.tag_id = '0;
    bus.tag_nested = 1'b0;
    bus.tag_len = '0;
    bus.node_ready = 1'b0;
    test_reset();
    test_nested_walk();
    test_double_pop();
    test_no_match();
    test_backpressure();
    test_errors();
    test_clr_in_emit();
    test_reset_in_emit();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
